// File: rtl/uarc_receiver_arbiter.sv
// uarc_receiver_arbiter
// ---------------------------------------------------------------------------
// Downstream stage of the core0 UARC receiver port bundle. Round-robin picks
// one requesting receiver bus per cycle and, within that bus, takes the
// highest-priority message type (kill > incept > stream > send). The winning
// request is acked for one cycle, and the message goes into a single-entry
// output register that the core's dispatch logic drains with valid/ready.
//
// Optional build macro: UARC_RX_KILL_PRIORITY_EN
//   defined   - when any enabled bus requests kill, only kill-requesting buses
//               take part in the round-robin, so kills preempt other traffic.
//   undefined - pure round-robin over buses, regardless of message type.
//
// Ports
//   clk, reset                     core clock; asynchronous active-low reset
//   receiver_enable                per-bus connected/enabled
//   receiver_kills/incepts/
//     streams/sends                per-bus request lines
//   receiver_*_acks                per-bus one-cycle accept pulses (at most
//                                  one bit set across all four vectors)
//   receiver_datas, receiver_self_permissions, receiver_self_addresses,
//     receiver_incept_permissions, receiver_incept_addresses
//                                  per-bus payload words
//   out_valid / out_ready          output buffer handshake
//   out_type                       0 send, 1 stream, 2 incept, 3 kill
//   out_bus                        source bus of the buffered message
//   out_data ... out_incept_address captured payload
// ---------------------------------------------------------------------------
module uarc_receiver_arbiter #(
    parameter int  WORD_MAG    = 5,
    parameter int  UARC_SETS   = 1,
    localparam int WORD_WIDTH  = 1 << WORD_MAG,
    localparam int TOTAL_BUSES = UARC_SETS * WORD_WIDTH,
    localparam int BUS_BITS    = $clog2(TOTAL_BUSES)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [TOTAL_BUSES-1:0]                  receiver_enable,
    input  logic [TOTAL_BUSES-1:0]                  receiver_kills,
    input  logic [TOTAL_BUSES-1:0]                  receiver_incepts,
    input  logic [TOTAL_BUSES-1:0]                  receiver_sends,
    input  logic [TOTAL_BUSES-1:0]                  receiver_streams,
    output logic [TOTAL_BUSES-1:0]                  receiver_kill_acks,
    output logic [TOTAL_BUSES-1:0]                  receiver_incept_acks,
    output logic [TOTAL_BUSES-1:0]                  receiver_send_acks,
    output logic [TOTAL_BUSES-1:0]                  receiver_stream_acks,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_datas,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_self_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_self_addresses,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_incept_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_incept_addresses,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [1:0]                              out_type,
    output logic [BUS_BITS-1:0]                     out_bus,
    output logic [WORD_WIDTH-1:0]                   out_data,
    output logic [WORD_WIDTH-1:0]                   out_self_permission,
    output logic [WORD_WIDTH-1:0]                   out_self_address,
    output logic [WORD_WIDTH-1:0]                   out_incept_permission,
    output logic [WORD_WIDTH-1:0]                   out_incept_address
);

    localparam logic [1:0] TYPE_SEND   = 2'd0;
    localparam logic [1:0] TYPE_STREAM = 2'd1;
    localparam logic [1:0] TYPE_INCEPT = 2'd2;
    localparam logic [1:0] TYPE_KILL   = 2'd3;

    logic [BUS_BITS-1:0]    rr_ptr;
    logic [TOTAL_BUSES-1:0] req;
    logic [TOTAL_BUSES-1:0] cand;
    logic                   can_accept;
    logic                   grant_any;
    logic                   grant;
    logic [BUS_BITS-1:0]    grant_idx;
    logic [1:0]             grant_type;
    logic [BUS_BITS:0]      idx_sum;
    logic [BUS_BITS-1:0]    idx;

    assign req = receiver_enable &
                 (receiver_kills | receiver_incepts | receiver_streams | receiver_sends);

`ifdef UARC_RX_KILL_PRIORITY_EN
    logic [TOTAL_BUSES-1:0] kill_req;
    assign kill_req = receiver_enable & receiver_kills;
`endif

    assign can_accept = !out_valid || out_ready;
    assign grant      = can_accept && grant_any;

    // First candidate at or after rr_ptr; the sum is one bit wider so the
    // wrap also works when TOTAL_BUSES is not a power of two.
    always_comb begin
        cand = req;
`ifdef UARC_RX_KILL_PRIORITY_EN
        if (|kill_req) cand = kill_req;
`endif
        grant_any = 1'b0;
        grant_idx = '0;
        idx_sum   = '0;
        idx       = '0;
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            idx_sum = {1'b0, rr_ptr} + (BUS_BITS+1)'(k);
            if (idx_sum >= (BUS_BITS+1)'(TOTAL_BUSES))
                idx_sum = idx_sum - (BUS_BITS+1)'(TOTAL_BUSES);
            idx = idx_sum[BUS_BITS-1:0];
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        if (receiver_kills[grant_idx])        grant_type = TYPE_KILL;
        else if (receiver_incepts[grant_idx]) grant_type = TYPE_INCEPT;
        else if (receiver_streams[grant_idx]) grant_type = TYPE_STREAM;
        else                                  grant_type = TYPE_SEND;
    end

    // Reset gates the acks directly so they drop the moment reset asserts,
    // not at the next edge.
    always_comb begin
        receiver_kill_acks   = '0;
        receiver_incept_acks = '0;
        receiver_stream_acks = '0;
        receiver_send_acks   = '0;
        if (grant && reset) begin
            case (grant_type)
                TYPE_KILL:   receiver_kill_acks[grant_idx]   = 1'b1;
                TYPE_INCEPT: receiver_incept_acks[grant_idx] = 1'b1;
                TYPE_STREAM: receiver_stream_acks[grant_idx] = 1'b1;
                default:     receiver_send_acks[grant_idx]   = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr                <= '0;
            out_valid             <= 1'b0;
            out_type              <= '0;
            out_bus               <= '0;
            out_data              <= '0;
            out_self_permission   <= '0;
            out_self_address      <= '0;
            out_incept_permission <= '0;
            out_incept_address    <= '0;
        end else if (grant) begin
            out_valid             <= 1'b1;
            out_type              <= grant_type;
            out_bus               <= grant_idx;
            out_data              <= receiver_datas[grant_idx];
            out_self_permission   <= receiver_self_permissions[grant_idx];
            out_self_address      <= receiver_self_addresses[grant_idx];
            out_incept_permission <= receiver_incept_permissions[grant_idx];
            out_incept_address    <= receiver_incept_addresses[grant_idx];
            rr_ptr <= (grant_idx == BUS_BITS'(TOTAL_BUSES - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// Testbench for uarc_receiver_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic against a behavioural model.
module tb_uarc_receiver_arbiter;

    localparam int WORD_MAG  = 5;
    localparam int UARC_SETS = 1;
    localparam int WW        = 1 << WORD_MAG;
    localparam int N         = UARC_SETS * WW;
    localparam int BB        = $clog2(N);
    localparam logic [N-1:0] ONE = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] en, kills, incepts, sends, streams;
    logic [N-1:0] kill_acks, incept_acks, send_acks, stream_acks;
    logic [N-1:0][WW-1:0] datas, sperms, saddrs, iperms, iaddrs;
    logic          out_valid, out_ready;
    logic [1:0]    out_type;
    logic [BB-1:0] out_bus;
    logic [WW-1:0] o_data, o_sperm, o_saddr, o_iperm, o_iaddr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uarc_receiver_arbiter #(.WORD_MAG(WORD_MAG), .UARC_SETS(UARC_SETS)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .receiver_enable             (en),
        .receiver_kills              (kills),
        .receiver_incepts            (incepts),
        .receiver_sends              (sends),
        .receiver_streams            (streams),
        .receiver_kill_acks          (kill_acks),
        .receiver_incept_acks        (incept_acks),
        .receiver_send_acks          (send_acks),
        .receiver_stream_acks        (stream_acks),
        .receiver_datas              (datas),
        .receiver_self_permissions   (sperms),
        .receiver_self_addresses     (saddrs),
        .receiver_incept_permissions (iperms),
        .receiver_incept_addresses   (iaddrs),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .out_type                    (out_type),
        .out_bus                     (out_bus),
        .out_data                    (o_data),
        .out_self_permission         (o_sperm),
        .out_self_address            (o_saddr),
        .out_incept_permission       (o_iperm),
        .out_incept_address          (o_iaddr)
    );

    task automatic clear_reqs();
        en = '1; kills = '0; incepts = '0; sends = '0; streams = '0;
    endtask

    task automatic set_payload(input int b, input logic [WW-1:0] base);
        datas[b]  = base;
        sperms[b] = base ^ 32'h1111_1111;
        saddrs[b] = base ^ 32'h2222_2222;
        iperms[b] = base ^ 32'h4444_4444;
        iaddrs[b] = base ^ 32'h8888_8888;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_reqs();
        out_ready = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        en = '1; kills = '1; incepts = '1; sends = '1; streams = '1;
        out_ready = 1'b1;
        for (int b = 0; b < N; b++) set_payload(b, 32'h0BAD_0000 + 32'(b));
        #2;
        checks++;
        if ({kill_acks, incept_acks, stream_acks, send_acks} !== '0) begin
            failures++; $display("FAIL reset_acks got=%0h exp=0", {kill_acks, incept_acks, stream_acks, send_acks});
        end
        checks++;
        if (out_valid !== 1'b0 || out_bus !== '0 || o_data !== '0) begin
            failures++; $display("FAIL reset_outputs got valid=%0b bus=%0d data=%0h exp 0/0/0", out_valid, out_bus, o_data);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (kill_acks !== ONE || {incept_acks, stream_acks, send_acks} !== '0) begin
            failures++; $display("FAIL release_first_grant got kill=%0h exp=1", kill_acks);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_bus !== '0 || out_type !== 2'd3 || o_data !== 32'h0BAD_0000) begin
            failures++; $display("FAIL release_capture got valid=%0b bus=%0d type=%0d data=%0h exp 1/0/3/bad0000", out_valid, out_bus, out_type, o_data);
        end
        checks++;
        if (kill_acks !== (ONE << 1)) begin
            failures++; $display("FAIL release_rr_ptr got kill=%0h exp=2", kill_acks);
        end
        // asynchronous reset in the middle of a cycle, buffer full
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || o_data !== '0 || {kill_acks, incept_acks, stream_acks, send_acks} !== '0) begin
            failures++; $display("FAIL async_reset got valid=%0b data=%0h kill=%0h exp 0/0/0", out_valid, o_data, kill_acks);
        end
        @(negedge clk);
        clear_reqs();
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        int seq[3] = '{0, 3, 5};
        do_reset();
        @(negedge clk);
        foreach (seq[i]) begin
            sends[seq[i]] = 1'b1;
            set_payload(seq[i], 32'hA000_0000 + 32'(seq[i]));
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                sends[seq[k-1]] = 1'b0;
            end
            #1;
            checks++;
            if (send_acks !== (ONE << seq[k]) || kill_acks !== '0) begin
                failures++; $display("FAIL rr_ack_%0d got=%0h exp=%0h", k, send_acks, ONE << seq[k]);
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_bus !== BB'(seq[k-1])) begin
                    failures++; $display("FAIL rr_out_%0d got valid=%0b bus=%0d exp 1/%0d", k, out_valid, out_bus, seq[k-1]);
                end
            end
        end
        @(negedge clk);
        sends[5] = 1'b0;
        #1;
        checks++;
        if (send_acks !== '0 || out_valid !== 1'b1 || out_bus !== BB'(5) || o_data !== 32'hA000_0005) begin
            failures++; $display("FAIL rr_last got ack=%0h valid=%0b bus=%0d data=%0h exp 0/1/5/a0000005", send_acks, out_valid, out_bus, o_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || o_data !== 32'hA000_0005) begin
            failures++; $display("FAIL rr_drain got valid=%0b data=%0h exp 0/a0000005", out_valid, o_data);
        end
    endtask

    task automatic test_type_priority();
        do_reset();
        @(negedge clk);
        kills[2] = 1'b1; sends[2] = 1'b1;
        set_payload(2, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (kill_acks !== (ONE << 2) || {incept_acks, stream_acks, send_acks} !== '0) begin
            failures++; $display("FAIL prio_kill_ack got kill=%0h send=%0h exp 4/0", kill_acks, send_acks);
        end
        @(negedge clk);
        kills[2] = 1'b0;
        #1;
        checks++;
        if (send_acks !== (ONE << 2) || kill_acks !== '0) begin
            failures++; $display("FAIL prio_send_ack got send=%0h exp=4", send_acks);
        end
        checks++;
        if (out_type !== 2'd3 || out_bus !== BB'(2) || o_data !== 32'hDEAD_BEEF || o_iaddr !== (32'hDEAD_BEEF ^ 32'h8888_8888)) begin
            failures++; $display("FAIL prio_kill_out got type=%0d bus=%0d data=%0h exp 3/2/deadbeef", out_type, out_bus, o_data);
        end
        @(negedge clk);
        sends[2] = 1'b0;
        #1;
        checks++;
        if (out_type !== 2'd0 || out_bus !== BB'(2)) begin
            failures++; $display("FAIL prio_send_out got type=%0d bus=%0d exp 0/2", out_type, out_bus);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        sends[1] = 1'b1;
        set_payload(1, 32'h1234_5678);
        #1;
        checks++;
        if (send_acks !== (ONE << 1)) begin
            failures++; $display("FAIL bp_first got=%0h exp=2", send_acks);
        end
        @(negedge clk);
        sends[1] = 1'b0;
        sends[4] = 1'b1;
        set_payload(4, 32'hCAFE_0004);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if ({kill_acks, incept_acks, stream_acks, send_acks} !== '0 || out_valid !== 1'b1 ||
                out_bus !== BB'(1) || o_data !== 32'h1234_5678 || out_type !== 2'd0) begin
                failures++; $display("FAIL bp_hold_%0d got ack=%0h valid=%0b bus=%0d data=%0h exp 0/1/1/12345678", c, send_acks, out_valid, out_bus, o_data);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (send_acks !== (ONE << 4)) begin
            failures++; $display("FAIL bp_release got=%0h exp=10", send_acks);
        end
        @(negedge clk);
        sends[4] = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_bus !== BB'(4) || o_data !== 32'hCAFE_0004) begin
            failures++; $display("FAIL bp_capture got valid=%0b bus=%0d data=%0h exp 1/4/cafe0004", out_valid, out_bus, o_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        sends[N-2] = 1'b1;
        #1;
        checks++;
        if (send_acks !== (ONE << (N-2))) begin
            failures++; $display("FAIL wrap_setup got=%0h exp=%0h", send_acks, ONE << (N-2));
        end
        @(negedge clk);
        sends[N-2] = 1'b0; sends[N-1] = 1'b1; sends[0] = 1'b1;
        #1;
        checks++;
        if (send_acks !== (ONE << (N-1))) begin
            failures++; $display("FAIL wrap_last got=%0h exp=%0h", send_acks, ONE << (N-1));
        end
        @(negedge clk);
        sends[N-1] = 1'b0;
        #1;
        checks++;
        if (send_acks !== ONE || out_bus !== BB'(N-1)) begin
            failures++; $display("FAIL wrap_zero got ack=%0h bus=%0d exp 1/%0d", send_acks, out_bus, N-1);
        end
        @(negedge clk);
        sends[0] = 1'b0;
        #1;
        checks++;
        if (out_bus !== '0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_out got bus=%0d valid=%0b exp 0/1", out_bus, out_valid);
        end
    endtask

    task automatic test_kill_preempt();
        do_reset();
        @(negedge clk);
        sends[1] = 1'b1; kills[6] = 1'b1;
        #1;
        checks++;
`ifdef UARC_RX_KILL_PRIORITY_EN
        if (kill_acks !== (ONE << 6) || send_acks !== '0) begin
            failures++; $display("FAIL kill_preempt got kill=%0h send=%0h exp 40/0", kill_acks, send_acks);
        end
`else
        if (send_acks !== (ONE << 1) || kill_acks !== '0) begin
            failures++; $display("FAIL kill_waits got kill=%0h send=%0h exp 0/2", kill_acks, send_acks);
        end
`endif
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_random();
        logic              m_valid = 1'b0;
        logic [1:0]        m_type  = '0;
        int                m_bus   = 0;
        int                m_rr    = 0;
        logic [5*WW-1:0]   m_pay   = '0;
        logic [4*N-1:0]    exp_acks;
        logic              can, any_kill, elig;
        int                g, b, t;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                en[i]      = ($urandom_range(7) != 0);
                kills[i]   = ($urandom_range(23) == 0);
                incepts[i] = ($urandom_range(11) == 0);
                streams[i] = ($urandom_range(11) == 0);
                sends[i]   = ($urandom_range(9) == 0);
                datas[i]   = $urandom; sperms[i] = $urandom; saddrs[i] = $urandom;
                iperms[i]  = $urandom; iaddrs[i] = $urandom;
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            can = !m_valid || out_ready;
            any_kill = 1'b0;
            for (int i = 0; i < N; i++) if (en[i] && kills[i]) any_kill = 1'b1;
            g = -1;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    b = (m_rr + k) % N;
                    elig = en[b] && (kills[b] || incepts[b] || streams[b] || sends[b]);
`ifdef UARC_RX_KILL_PRIORITY_EN
                    if (any_kill) elig = en[b] && kills[b];
`endif
                    if (g < 0 && elig) g = b;
                end
            end
            exp_acks = '0;
            t = 0;
            if (g >= 0) begin
                t = kills[g] ? 3 : incepts[g] ? 2 : streams[g] ? 1 : 0;
                exp_acks[t*N + g] = 1'b1;
            end
            checks++;
            if ({kill_acks, incept_acks, stream_acks, send_acks} !== exp_acks) begin
                failures++; $display("FAIL rand_acks cycle %0d got=%0h exp=%0h", c, {kill_acks, incept_acks, stream_acks, send_acks}, exp_acks);
            end
            checks++;
            if (out_valid !== m_valid || out_type !== m_type || out_bus !== BB'(m_bus)) begin
                failures++; $display("FAIL rand_out cycle %0d got valid=%0b type=%0d bus=%0d exp %0b/%0d/%0d", c, out_valid, out_type, out_bus, m_valid, m_type, m_bus);
            end
            checks++;
            if ({o_data, o_sperm, o_saddr, o_iperm, o_iaddr} !== m_pay) begin
                failures++; $display("FAIL rand_payload cycle %0d got=%0h exp=%0h", c, {o_data, o_sperm, o_saddr, o_iperm, o_iaddr}, m_pay);
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_type  = 2'(t);
                m_bus   = g;
                m_pay   = {datas[g], sperms[g], saddrs[g], iperms[g], iaddrs[g]};
                m_rr    = (g + 1) % N;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        out_ready = 1'b1;
        datas = '0; sperms = '0; saddrs = '0; iperms = '0; iaddrs = '0;
        test_reset();
        test_round_robin();
        test_type_priority();
        test_backpressure();
        test_wrap();
        test_kill_preempt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
